// File: rtl/rf_write_buffer.sv
// Register-file write buffer: a circular FIFO between writeback and the bit-cell array write port,
// with youngest-match bypass of pending writes onto two read ports.
module rf_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 16,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [$clog2(NREG)-1:0]  wb_reg,
  input  logic [W-1:0]             wb_data,
  input  logic                     rf_busy,
  output logic [NREG-1:0]          rf_wr_en,
  output logic [W-1:0]             rf_wr_data,
  input  logic [$clog2(NREG)-1:0]  rd_reg1,
  input  logic [$clog2(NREG)-1:0]  rd_reg2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [W-1:0]             byp_data1,
  output logic [W-1:0]             byp_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [RW-1:0] ent_reg_q  [DEPTH];
  logic [W-1:0]  ent_data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          push, pop, wr_go;
  logic [PW-1:0] byp_idx;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign wb_ready = (count_q < CW'(DEPTH));

  // Writes to R0 handshake normally but are dropped here.
  assign push = wb_valid && wb_ready && (wb_reg != '0);

  // Stored entries never target R0, so a non-empty, non-busy buffer always writes a row.
  assign wr_go      = !empty && !rf_busy;
  assign rf_wr_en   = wr_go ? (NREG'(1) << ent_reg_q[head_q]) : '0;
  assign rf_wr_data = wr_go ? ent_data_q[head_q] : '0;
  assign pop        = |rf_wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_reg_q[tail_q]  <= wb_reg;
        ent_data_q[tail_q] <= wb_data;
        tail_q             <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; the head entry being drained
  // this cycle is still included.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    byp_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rd_reg1 != '0) && (ent_reg_q[byp_idx] == rd_reg1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = ent_data_q[byp_idx];
        end
        if ((rd_reg2 != '0) && (ent_reg_q[byp_idx] == rd_reg2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = ent_data_q[byp_idx];
        end
      end
    end
  end

endmodule

// File: doc/rf_write_buffer.md
RF_WRITE_BUFFER -- requirements
Module: rf_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered write entries (power of two, >=2).
REQ-002 SHALL have parameter NREG, default 16: architectural registers; R0 is hardwired zero.
REQ-003 SHALL have parameter W, default 16: register data width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wb_valid  in  1  writeback stage offers a write.
REQ-007 SHALL have port wb_ready  out  1  buffer can accept a write this cycle.
REQ-008 SHALL have port wb_reg  in  log2(NREG)  destination register index.
REQ-009 SHALL have port wb_data  in  W  write data.
REQ-010 SHALL have port rf_busy  in  1  register-file write port unavailable this cycle (test/scan access).
REQ-011 SHALL have port rf_wr_en  out  NREG  one-hot row WriteEnable into the bit-cell array.
REQ-012 SHALL have port rf_wr_data  out  W  D input broadcast to the bit-cell array.
REQ-013 SHALL have ports rd_reg1, rd_reg2  in  log2(NREG)  read-port indices from decode.
REQ-014 SHALL have ports byp_hit1, byp_hit2  out  1  a pending buffered write matches the read index.
REQ-015 SHALL have ports byp_data1, byp_data2  out  W  forwarded data, valid when the matching hit is 1.
REQ-016 SHALL have port count  out  log2(DEPTH)+1  occupied entries.
REQ-017 SHALL have port empty  out  1  count==0.

Function
REQ-018 SHALL be a circular FIFO: head/tail pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-019 SHALL set wb_ready = (count < DEPTH); no push while full, even when a pop occurs that cycle.
REQ-020 SHALL accept a write on the edge where wb_valid && wb_ready.
REQ-021 SHALL complete the handshake for an accepted write with wb_reg==0 without enqueuing it (count unchanged).
REQ-022 SHALL drive rf_wr_en as onehot(head.reg) and rf_wr_data = head.data combinationally whenever !empty && !rf_busy; otherwise rf_wr_en = 0.
REQ-023 SHALL pop the head on every edge where rf_wr_en != 0 (one RF write per cycle).
REQ-024 SHALL drive RF writes at least one cycle after acceptance; no same-cycle pass-through from wb_* to rf_*.
REQ-025 SHALL update count on simultaneous push and pop as count+1-1 = unchanged, with both pointers advancing.
REQ-026 SHALL drain entries in acceptance order, including repeated writes to the same register.
REQ-027 SHALL compute bypass per read port over stored entries only (not the incoming wb_* write).
REQ-028 SHALL select the youngest matching entry when several stored entries match.
REQ-029 SHALL force byp_hit to 0 when rd_reg==0; byp_data SHALL be 0 when hit is 0.
REQ-030 SHALL include the head entry being written this cycle in bypass matching.
REQ-031 SHALL retain content and hold rf_wr_en at 0 while rf_busy is held, for any number of cycles.

Reset
REQ-032 SHALL, while rst==0 and without waiting for clk, clear pointers, set count=0, empty=1, wb_ready=1, rf_wr_en=0, byp_hit1/2=0, and invalidate all entries.
REQ-033 SHALL discard in-flight contents when reset asserts mid-operation; no RF write occurs during reset or on the first edge after release.

Verification
REQ-034 SHALL cover: reset, then push R3=0x1234 -> next cycle rf_wr_en=0x0008, rf_wr_data=0x1234; following cycle empty=1.
REQ-035 SHALL cover: rf_busy=1, push R1..R4 -> count=4, wb_ready=0, a 5th wb_valid is not accepted; release rf_busy -> writes R1,R2,R3,R4 on 4 consecutive cycles.
REQ-036 SHALL cover: rf_busy=1, push R5=0xAAAA then R5=0xBBBB; rd_reg1=5 -> byp_hit1=1, byp_data1=0xBBBB; rd_reg2=0 -> byp_hit2=0.
REQ-037 SHALL cover: push R0=0xFFFF -> handshake completes, count stays 0, no rf_wr_en bit set.
REQ-038 SHALL cover: count=2 with push and pop in the same cycle -> count stays 2; pointers wrap correctly across 3*DEPTH continuous transfers.
REQ-039 SHALL cover: rst driven low mid-cycle with count=3 -> count=0 and rf_wr_en=0 immediately, before the next clk edge.
